// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lets two requesters share one registered ALU.
// One operation is in flight at a time: accept, execute for one cycle, then hold the result until it is consumed.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_data,
    input  logic             resp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_data,
    input  logic             resp1_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             gnt;
    logic             prio;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] res_q;

    logic             sel;
    logic             accept;
    logic             resp_done;
    logic             shamt_oob;
    logic [WIDTH-1:0] alu_res;

    logic [1:0]       req_valid;
    logic [1:0]       req_rdy;
    logic [1:0]       resp_vld;
    logic [1:0]       resp_rdy;
    logic [WIDTH-1:0] resp_dat [2];

    assign req_valid = {req1_valid, req0_valid};
    assign resp_rdy  = {resp1_ready, resp0_ready};

    // A lone requester wins outright; a tie goes to the favoured one.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid)
            sel = prio;
        else if (req1_valid)
            sel = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_rdy[gi]  = rst_n && (state == IDLE) && req_valid[gi] && (sel == 1'(gi));
            assign resp_vld[gi] = (state == RESP) && (gnt == 1'(gi));
            assign resp_dat[gi] = resp_vld[gi] ? res_q : '0;
        end
    endgenerate

    assign req0_ready  = req_rdy[0];
    assign req1_ready  = req_rdy[1];
    assign resp0_valid = resp_vld[0];
    assign resp1_valid = resp_vld[1];
    assign resp0_data  = resp_dat[0];
    assign resp1_data  = resp_dat[1];
    assign busy        = (state != IDLE);

    assign accept    = |req_rdy;
    assign resp_done = resp_rdy[gnt];

    // Shift amounts of WIDTH or more saturate instead of relying on operator semantics.
    assign shamt_oob = (b_q >= WIDTH'(WIDTH));

    always_comb begin
        alu_res = '0;
        case (op_q)
            3'd0:    alu_res = a_q + b_q;
            3'd1:    alu_res = a_q - b_q;
            3'd2:    alu_res = a_q & b_q;
            3'd3:    alu_res = a_q | b_q;
            3'd4:    alu_res = shamt_oob ? '0 : (a_q >> b_q);
            3'd5:    alu_res = shamt_oob ? {WIDTH{a_q[WIDTH-1]}} : WIDTH'($signed(a_q) >>> b_q);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            prio  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel ? req1_a  : req0_a;
                        b_q   <= sel ? req1_b  : req0_b;
                        op_q  <= sel ? req1_op : req0_op;
                        gnt   <= sel;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_res;
                    state <= RESP;
                end
                RESP: begin
                    // Priority flips only when a response is actually consumed.
                    if (resp_done) begin
                        prio  <= ~gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
